// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: FSM state
// encoding, multiply iteration count and the ALU opcodes that select it.
// Build option: MULTDIV_RADIX4_EN selects radix-4 Booth multiply (2 bits/cycle).
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

`ifdef MULTDIV_RADIX4_EN
    localparam int MUL_BITS_PER_CYCLE = 2;
`else
    localparam int MUL_BITS_PER_CYCLE = 1;
`endif

    localparam int DEFAULT_WIDTH = 32;

    // Number of MUL-state cycles for a given operand width.
    function automatic int mul_iters(input int width);
        return width / MUL_BITS_PER_CYCLE;
    endfunction

    localparam int MUL_ITERS = mul_iters(DEFAULT_WIDTH);

    // ALU opcodes decoded into ctrl_MULT / ctrl_DIV by the issue logic.
    localparam logic [4:0] ALU_OP_MUL = 5'b00110;
    localparam logic [4:0] ALU_OP_DIV = 5'b00111;

endpackage

// File: rtl/multdiv_iter_div.sv
// Magnitude restoring divider: one quotient bit per step. The dividend is
// shifted out of the quotient register MSB-first while quotient bits are
// shifted in at the bottom. The remainder is kept only as working state.
module div_iter
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quotient_o
);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   shifted;
    logic             ge;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        ge      = (shifted >= {1'b0, dvs_q});
        rem_d   = ge ? WIDTH'(shifted - {1'b0, dvs_q}) : shifted[WIDTH-1:0];
        quo_d   = {quo_q[WIDTH-2:0], ge};
    end

    // Load operands on start, otherwise advance one step per enabled cycle.
    always_ff @(posedge clk) begin
        if (srst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load_i) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            dvs_q <= divisor_i;
        end else if (step_i) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
        end
    end

    assign quotient_o = quo_q;

endmodule

// File: rtl/multdiv_iter.sv
// Iterative signed multiply/divide unit for the execute stage.
// Owns the control FSM, sign handling and the shift-add multiplier; the
// magnitude divider lives in div_iter. Results are registered when leaving
// DONE, so RDY is a one-cycle pulse in the cycle following DONE.
// Build option: MULTDIV_RADIX4_EN selects radix-4 Booth multiply
// (WIDTH/2 MUL cycles); otherwise radix-2 with a final sign correction.
// WIDTH must be even and >= 4.
module multdiv_iter
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             flush,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [TAG_W-1:0] tag_in,
    output logic             busy,
    output logic             data_resultRDY,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic [TAG_W-1:0] tag_out
);

    localparam int CW         = $clog2(WIDTH + 1);
    localparam int HW         = WIDTH + 2;
    localparam int MUL_CYCLES = mul_iters(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic             start_mul, start_div, complete;
    logic             mul_last, div_last;

    // Captured operation context.
    logic [WIDTH-1:0] a_q;
    logic [TAG_W-1:0] tag_q;
    logic             is_div_q;
    logic             sign_q;
    logic             dvz_q;
    logic             ovf_q;

    // Multiply accumulator: high part carries two guard bits.
    logic [HW-1:0]    acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [HW-1:0]    a_ext;
    logic [HW-1:0]    mul_pp;
    logic [HW-1:0]    mul_sum;
`ifdef MULTDIV_RADIX4_EN
    logic             booth_q, booth_d;
`endif

    // Divider interface.
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] quotient;

    // Finished result, valid while in DONE.
    logic [WIDTH-1:0] fin_result;
    logic             fin_exc;

    // Output registers.
    logic             rdy_q;
    logic [WIDTH-1:0] result_q;
    logic             exc_q;
    logic [TAG_W-1:0] tag_out_q;

    assign mul_last = (cnt_q == CW'(MUL_CYCLES - 1));
    assign div_last = (cnt_q == CW'(WIDTH - 1));
    assign a_mag    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign b_mag    = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    assign a_ext    = {{2{a_q[WIDTH-1]}}, a_q};

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and start/complete strobes; MULT wins over DIV, flush wins over both.
    always_comb begin
        state_d   = state_q;
        start_mul = 1'b0;
        start_div = 1'b0;
        complete  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!flush) begin
                    if (ctrl_MULT) begin
                        state_d   = MUL;
                        start_mul = 1'b1;
                    end else if (ctrl_DIV) begin
                        state_d   = DIV;
                        start_div = 1'b1;
                    end
                end
            end
            MUL: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (mul_last) begin
                    state_d = DONE;
                end
            end
            DIV: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (div_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d  = IDLE;
                complete = !flush;
            end
            default: state_d = IDLE;
        endcase
    end

    // Iteration counter: cleared on start, saturates on the last iteration.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (start_mul || start_div) begin
            cnt_q <= '0;
        end else if ((state_q == MUL && !mul_last) || (state_q == DIV && !div_last)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Capture operation context at start.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_q      <= '0;
            tag_q    <= '0;
            is_div_q <= 1'b0;
            sign_q   <= 1'b0;
            dvz_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (start_mul || start_div) begin
            a_q      <= data_operandA;
            tag_q    <= tag_in;
            is_div_q <= start_div;
            sign_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dvz_q    <= (data_operandB == '0);
            ovf_q    <= (data_operandA == MOST_NEG) && (data_operandB == '1);
        end
    end

`ifdef MULTDIV_RADIX4_EN
    // Radix-4 Booth step: recode two multiplier bits plus the previous one, shift by two.
    always_comb begin
        mul_pp = '0;
        case ({acc_lo_q[1:0], booth_q})
            3'b001, 3'b010: mul_pp = a_ext;
            3'b011:         mul_pp = a_ext << 1;
            3'b100:         mul_pp = -(a_ext << 1);
            3'b101, 3'b110: mul_pp = -a_ext;
            default:        mul_pp = '0;
        endcase
        mul_sum  = acc_hi_q + mul_pp;
        acc_hi_d = {{2{mul_sum[HW-1]}}, mul_sum[HW-1:2]};
        acc_lo_d = {mul_sum[1:0], acc_lo_q[WIDTH-1:2]};
        booth_d  = acc_lo_q[1];
    end

    // Multiply accumulator update.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            booth_q  <= 1'b0;
        end else if (start_mul) begin
            acc_hi_q <= '0;
            acc_lo_q <= data_operandB;
            booth_q  <= 1'b0;
        end else if (state_q == MUL) begin
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            booth_q  <= booth_d;
        end
    end
`else
    // Radix-2 shift-add step; the multiplier sign bit carries negative weight, so the last step subtracts.
    always_comb begin
        mul_pp = '0;
        if (acc_lo_q[0]) begin
            mul_pp = mul_last ? -a_ext : a_ext;
        end
        mul_sum  = acc_hi_q + mul_pp;
        acc_hi_d = {mul_sum[HW-1], mul_sum[HW-1:1]};
        acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end

    // Multiply accumulator update.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_hi_q <= '0;
            acc_lo_q <= '0;
        end else if (start_mul) begin
            acc_hi_q <= '0;
            acc_lo_q <= data_operandB;
        end else if (state_q == MUL) begin
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
        end
    end
`endif

    div_iter #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk        (clock),
        .srst       (reset),
        .load_i     (start_div),
        .step_i     (state_q == DIV),
        .dividend_i (a_mag),
        .divisor_i  (b_mag),
        .quotient_o (quotient)
    );

    // Final result: product low half with overflow check, or signed quotient with special cases.
    always_comb begin
        fin_result = acc_lo_q;
        fin_exc    = (acc_hi_q[WIDTH-1:0] != {WIDTH{acc_lo_q[WIDTH-1]}});
        if (is_div_q) begin
            if (dvz_q) begin
                fin_result = '0;
            end else if (sign_q) begin
                fin_result = -quotient;
            end else begin
                fin_result = quotient;
            end
            fin_exc = dvz_q | ovf_q;
        end
    end

    // Output registers: RDY pulses for one cycle, payload holds until the next completion.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdy_q     <= 1'b0;
            result_q  <= '0;
            exc_q     <= 1'b0;
            tag_out_q <= '0;
        end else begin
            rdy_q <= complete;
            if (complete) begin
                result_q  <= fin_result;
                exc_q     <= fin_exc;
                tag_out_q <= tag_q;
            end
        end
    end

    assign busy           = (state_q != IDLE);
    assign data_resultRDY = rdy_q;
    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign tag_out        = tag_out_q;

endmodule

// File: tb/tb_multdiv_iter.sv
// Testbench for multdiv_iter (WIDTH=32, TAG_W=5): directed cases plus random
// operations against a plain-arithmetic reference model.
// Build option: MULTDIV_RADIX4_EN shortens the expected multiply latency.
module tb_multdiv_iter;
    import multdiv_pkg::*;

    localparam int W  = 32;
    localparam int TW = 5;
`ifdef MULTDIV_RADIX4_EN
    localparam int MUL_LAT = W / 2 + 2;
`else
    localparam int MUL_LAT = W + 2;
`endif
    localparam int DIV_LAT = W + 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          ctrl_MULT = 1'b0;
    logic          ctrl_DIV = 1'b0;
    logic          flush = 1'b0;
    logic [W-1:0]  data_operandA = '0;
    logic [W-1:0]  data_operandB = '0;
    logic [TW-1:0] tag_in = '0;
    logic          busy;
    logic          data_resultRDY;
    logic [W-1:0]  data_result;
    logic          data_exception;
    logic [TW-1:0] tag_out;

    int tests_run = 0;
    int tests_failed = 0;

    logic [W-1:0]  last_result = '0;
    logic          last_exc = 1'b0;
    logic [TW-1:0] last_tag = '0;

    multdiv_iter #(.WIDTH(W), .TAG_W(TW)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .flush          (flush),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .tag_in         (tag_in),
        .busy           (busy),
        .data_resultRDY (data_resultRDY),
        .data_result    (data_result),
        .data_exception (data_exception),
        .tag_out        (tag_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: signed product / truncating quotient with the documented special cases.
    function automatic void model(input bit is_mul, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic e);
        int     sa;
        int     sb;
        int     lo;
        longint p;
        sa = a;
        sb = b;
        if (is_mul) begin
            p  = longint'(sa) * longint'(sb);
            lo = int'(p[31:0]);
            r  = p[31:0];
            e  = (p != longint'(lo));
        end else if (sb == 0) begin
            r = '0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && sb == -1) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            r = 32'(sa / sb);
            e = 1'b0;
        end
    endfunction

    function automatic logic [W-1:0] pick();
        int          v;
        logic [15:0] h;
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return '0;
            3: begin
                v = int'($urandom_range(0, 40)) - 20;
                return 32'(v);
            end
            4: begin
                h = 16'($urandom);
                return {{16{h[15]}}, h};
            end
            default: return $urandom;
        endcase
    endfunction

    task automatic drive_start(input bit mul, input bit div, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [TW-1:0] tag);
        ctrl_MULT     = mul;
        ctrl_DIV      = div;
        data_operandA = a;
        data_operandB = b;
        tag_in        = tag;
    endtask

    // Issue one op, optionally pulse ctrl_MULT while busy, and check the completion.
    task automatic run_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [TW-1:0] tag, input bit both, input int p1, input int p2);
        bit           is_mul;
        bit           seen;
        int           n;
        int           lat;
        int           extra;
        logic [W-1:0] er;
        logic         ee;
        is_mul = both || (op == ALU_OP_MUL);
        model(is_mul, a, b, er, ee);
        lat = is_mul ? MUL_LAT : DIV_LAT;
        @(negedge clock);
        drive_start(is_mul, both || (op == ALU_OP_DIV), a, b, tag);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            ctrl_MULT     = (n == p1) || (n == p2);
            ctrl_DIV      = 1'b0;
            data_operandA = $urandom;
            data_operandB = $urandom;
            tag_in        = TW'($urandom_range(0, 31));
            if (n == 1) check("busy_on_start", 64'(busy), 64'd1);
            if (data_resultRDY) seen = 1'b1;
        end
        ctrl_MULT = 1'b0;
        check("latency", 64'(n), 64'(lat));
        check("result", 64'(data_result), 64'(er));
        check("exception", 64'(data_exception), 64'(ee));
        check("tag_out", 64'(tag_out), 64'(tag));
        last_result = er;
        last_exc    = ee;
        last_tag    = tag;
        $display("[TB] %s a=0x%08h b=0x%08h tag=%0d -> result=0x%08h exc=%0b after %0d cycles",
                 is_mul ? "MUL" : "DIV", a, b, tag, data_result, data_exception, n);
        @(posedge clock);
        @(negedge clock);
        check("rdy_single_pulse", 64'(data_resultRDY), 64'd0);
        check("result_held", 64'(data_result), 64'(er));
        if (p1 > 0) begin
            extra = 0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clock);
                @(negedge clock);
                extra += int'(data_resultRDY);
            end
            check("no_extra_rdy", 64'(extra), 64'd0);
        end
    endtask

    // Start an op, flush it after flush_at cycles, and check it vanished without trace.
    task automatic run_flush(input bit is_mul, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [TW-1:0] tag, input int flush_at);
        int rdy_cnt;
        rdy_cnt = 0;
        @(negedge clock);
        drive_start(is_mul, !is_mul, a, b, tag);
        for (int n = 1; n <= flush_at; n++) begin
            @(posedge clock);
            @(negedge clock);
            ctrl_MULT = 1'b0;
            ctrl_DIV  = 1'b0;
            rdy_cnt  += int'(data_resultRDY);
            if (n == flush_at) flush = 1'b1;
        end
        @(posedge clock);
        @(negedge clock);
        flush = 1'b0;
        check("busy_after_flush", 64'(busy), 64'd0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            @(negedge clock);
            rdy_cnt += int'(data_resultRDY);
        end
        check("no_rdy_after_flush", 64'(rdy_cnt), 64'd0);
        check("flush_result_held", 64'(data_result), 64'(last_result));
        check("flush_tag_held", 64'(tag_out), 64'(last_tag));
        $display("[TB] FLUSH %s a=0x%08h b=0x%08h after %0d cycles -> busy=%0b",
                 is_mul ? "MUL" : "DIV", a, b, flush_at, busy);
    endtask

    initial begin
        logic [4:0] op;
        int rdy_cnt;

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_rdy", 64'(data_resultRDY), 64'd0);
        check("reset_result", 64'(data_result), 64'd0);
        check("reset_exc", 64'(data_exception), 64'd0);
        check("reset_tag", 64'(tag_out), 64'd0);

        run_op(ALU_OP_MUL, 32'd7, -32'sd6, 5'd12, 1'b0, 0, 0);
        check("mul_7x-6_const", 64'(data_result), 64'h0000_0000_FFFF_FFD6);
        run_op(ALU_OP_MUL, 32'h0001_0000, 32'h0001_0000, 5'd3, 1'b0, 0, 0);
        check("mul_ovf_const", 64'(data_exception), 64'd1);
        run_op(ALU_OP_MUL, 32'h7FFF_FFFF, 32'd1, 5'd4, 1'b0, 0, 0);
        run_op(ALU_OP_MUL, -32'sd3, -32'sd5, 5'd9, 1'b0, 0, 0);
        check("mul_-3x-5_const", 64'(data_result), 64'd15);
        run_op(ALU_OP_DIV, -32'sd100, 32'd7, 5'd5, 1'b0, 0, 0);
        check("div_-100/7_const", 64'(data_result), 64'h0000_0000_FFFF_FFF2);
        run_op(ALU_OP_DIV, 32'd5, 32'd0, 5'd6, 1'b0, 0, 0);
        run_op(ALU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 1'b0, 0, 0);

        run_flush(1'b1, 32'd123, 32'd456, 5'd20, 10);
        run_op(ALU_OP_DIV, 32'd9, 32'd3, 5'd21, 1'b0, 0, 0);
        check("div_9/3_const", 64'(data_result), 64'd3);

        run_op(ALU_OP_DIV, 32'd1000, -32'sd7, 5'd8, 1'b0, 5, 20);
        run_op(ALU_OP_DIV, 32'd6, 32'd7, 5'd30, 1'b1, 0, 0);
        check("both_high_mul_const", 64'(data_result), 64'd42);

        run_flush(1'b1, 32'd11, 32'd13, 5'd15, MUL_LAT - 1);
        run_flush(1'b0, 32'd50, 32'd5, 5'd16, 20);

        // Start presented together with flush in IDLE must be dropped.
        @(negedge clock);
        drive_start(1'b1, 1'b0, 32'd2, 32'd2, 5'd1);
        flush = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        flush = 1'b0;
        check("flush_start_busy", 64'(busy), 64'd0);
        rdy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            @(negedge clock);
            rdy_cnt += int'(data_resultRDY);
        end
        check("flush_start_no_rdy", 64'(rdy_cnt), 64'd0);
        $display("[TB] FLUSH+START in IDLE -> busy=%0b rdy pulses=%0d", busy, rdy_cnt);

        // Reset in the middle of an op clears everything.
        @(negedge clock);
        drive_start(1'b0, 1'b1, 32'd77, 32'd7, 5'd9);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            @(negedge clock);
            ctrl_DIV = 1'b0;
        end
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("midop_reset_busy", 64'(busy), 64'd0);
        check("midop_reset_result", 64'(data_result), 64'd0);
        check("midop_reset_tag", 64'(tag_out), 64'd0);
        $display("[TB] RESET mid-op -> busy=%0b result=0x%08h", busy, data_result);
        last_result = '0;
        last_exc    = 1'b0;
        last_tag    = '0;

        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 1) == 1) ? ALU_OP_MUL : ALU_OP_DIV;
            run_op(op, pick(), pick(), TW'($urandom_range(0, 31)), 1'b0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
